collatz_range: RTL and testbench

Computes Collatz sequence lengths for `RAM_WORDS` consecutive starting values beginning at `start`, stores them in an internal RAM, then serves them by address. It is the engine under the lab1 display top, which drives it with the debounced `go` and a `start` bus and displays `count`. Computation is one Collatz step per clock through a single iterator. After completion, the block answers synchronous reads indexed by `start`.

---
 rtl/collatz_pkg.sv | 19 +
 rtl/collatz_iter.sv | 67 ++++++
 rtl/collatz_range.sv | 116 +++++++++++
 tb/tb_collatz_range.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared defaults, saturation constant and state encoding for collatz_range
package collatz_pkg;

  localparam int RAM_WORDS_DEF     = 256;
  localparam int RAM_ADDR_BITS_DEF = 8;
  localparam int N_BITS_DEF        = 32;
  localparam int COUNT_BITS_DEF    = 16;

  localparam logic [COUNT_BITS_DEF-1:0] COUNT_SAT = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/collatz_iter.sv
// rtl/collatz_iter.sv - single Collatz iterator: one step per clock, term counter, overflow detect
module collatz_iter
  import collatz_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int COUNT_BITS = COUNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld,
  input  logic [N_BITS-1:0]     n_in,
  output logic                  fin,
  output logic [COUNT_BITS-1:0] cnt
);

  logic [N_BITS-1:0]     n_q, n_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [N_BITS+1:0]     triple;
  logic                  at_end;
  logic                  ovf_now;

  always_comb begin
    triple  = {2'b00, n_q} + {1'b0, n_q, 1'b0} + {{(N_BITS+1){1'b0}}, 1'b1};
    at_end  = (n_q[N_BITS-1:1] == '0);
    ovf_now = n_q[0] && (triple[N_BITS+1:N_BITS] != 2'b00);
    // Once finished the iterator freezes, so the result stays valid through WRITE and idle.
    fin     = at_end || ovf_q || ovf_now;

    n_d   = n_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (ld) begin
      n_d   = n_in;
      cnt_d = COUNT_BITS'(1);
      ovf_d = 1'b0;
    end else if (!at_end && !ovf_q) begin
      if (ovf_now) begin
        ovf_d = 1'b1;
      end else begin
        n_d   = n_q[0] ? triple[N_BITS-1:0] : (n_q >> 1);
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + COUNT_BITS'(1);
      end
    end

    if (n_q == '0) begin
      cnt = '0;
    end else if (ovf_q) begin
      cnt = '1;
    end else begin
      cnt = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/collatz_range.sv
// rtl/collatz_range.sv - computes Collatz lengths for RAM_WORDS consecutive values, then serves them by address
module collatz_range
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = RAM_WORDS_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int N_BITS        = N_BITS_DEF,
  parameter int COUNT_BITS    = COUNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [N_BITS-1:0]     start,
  output logic                  done,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] count
);

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [N_BITS-1:0]        base_q, base_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic [COUNT_BITS-1:0]    count_q, count_d;
  logic [COUNT_BITS-1:0]    ram [RAM_WORDS];

  logic                  ld;
  logic                  fin;
  logic [COUNT_BITS-1:0] cnt;
  logic [N_BITS-1:0]     n_in;

  assign n_in = base_q + N_BITS'(idx_q);

  collatz_iter #(
    .N_BITS    (N_BITS),
    .COUNT_BITS(COUNT_BITS)
  ) u_iter (
    .clk  (clk),
    .reset(reset),
    .ld   (ld),
    .n_in (n_in),
    .fin  (fin),
    .cnt  (cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    busy_d  = busy_q;
    ld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          base_d  = start;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld      = 1'b1;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (fin) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx_q == RAM_ADDR_BITS'(RAM_WORDS-1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + RAM_ADDR_BITS'(1);
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_q == ST_FIN);
    // The read port is only live while idle and not about to start a run.
    count_d = (state_q == ST_IDLE && !go) ? ram[start[RAM_ADDR_BITS-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_WRITE) begin
      ram[idx_q] <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_collatz_range.sv
// tb/tb_collatz_range.sv - scoreboard bench for collatz_range (4-word and default instances)
module tb_collatz_range;
  import collatz_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go4, god;
  logic [31:0] start4, startd;
  logic        done4, busy4, doned, busyd;
  logic [15:0] count4, countd;

  always #5 clk = ~clk;

  collatz_range #(
    .RAM_WORDS    (4),
    .RAM_ADDR_BITS(2),
    .N_BITS       (32),
    .COUNT_BITS   (16)
  ) dut4 (
    .clk  (clk),
    .reset(reset),
    .go   (go4),
    .start(start4),
    .done (done4),
    .busy (busy4),
    .count(count4)
  );

  collatz_range dutd (
    .clk  (clk),
    .reset(reset),
    .go   (god),
    .start(startd),
    .done (doned),
    .busy (busyd),
    .count(countd)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  function automatic void model(input logic [31:0] n0, output logic [15:0] c, output int t);
    longint unsigned n;
    logic [15:0] terms;
    n = 64'(n0);
    t = 0;
    terms = 16'd1;
    if (n == 0) begin
      c = 16'd0;
      t = 1;
      return;
    end
    forever begin
      t++;
      if (n == 1) begin
        c = terms;
        return;
      end
      if (n % 2 == 1) begin
        if (3 * n + 1 > 64'hFFFF_FFFF) begin
          c = COUNT_SAT;
          return;
        end
        n = 3 * n + 1;
      end else begin
        n = n / 2;
      end
      if (terms != 16'hFFFF) terms++;
    end
  endfunction

  function automatic int push_run(input logic [31:0] s);
    int edges = 1;
    int t;
    logic [15:0] c;
    for (int i = 0; i < 4; i++) begin
      model(s + 32'(i), c, t);
      exp_q.push_back(c);
      edges += t + 2;
    end
    return edges;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done4(input int exp_edges, input int glitch_at);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 3000) begin
      tick();
      k++;
      if (glitch_at > 0 && k == glitch_at) go4 = 1'b1;
      else if (glitch_at > 0 && k == glitch_at + 1) go4 = 1'b0;
      if (done4 === 1'b1) begin
        seen = 1;
        checks++;
        if (k !== exp_edges) begin
          errors++;
          $display("FAIL done_timing: done after %0d edges, expected %0d", k, exp_edges);
        end
        checks++;
        if (busy4 !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: busy=%b, expected 0", busy4);
        end
      end else begin
        checks++;
        if (busy4 !== 1'b1) begin
          errors++;
          $display("FAIL busy_during_run: edge %0d busy=%b, expected 1", k, busy4);
        end
        checks++;
        if (count4 !== 16'd0) begin
          errors++;
          $display("FAIL count_while_busy: edge %0d count=%0d, expected 0", k, count4);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d edges", k);
    end
  endtask

  task automatic check_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL quiet_after_done: cycle %0d done=%b busy=%b, expected 0/0", i, done4, busy4);
      end
    end
  endtask

  task automatic readback4();
    logic [15:0] exp;
    for (int a = 0; a < 4; a++) begin
      start4 = 32'(a);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (count4 !== exp) begin
        errors++;
        $display("FAIL readback addr %0d: count=%0h, expected %0h", a, count4, exp);
      end
    end
  endtask

  task automatic run4(input logic [31:0] s, input int glitch_at);
    int e;
    e = push_run(s);
    start4 = s;
    go4 = 1'b1;
    tick();
    go4 = 1'b0;
    wait_done4(e, glitch_at);
    check_quiet(2);
    readback4();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go4 = 1'b0;
    god = 1'b0;
    start4 = '0;
    startd = '0;
    repeat (3) tick();
    checks += 3;
    if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done4: %b, expected 0", done4); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: %b, expected 0", busy4); end
    if (count4 !== 16'd0) begin errors++; $display("FAIL reset_count4: %0h, expected 0", count4); end
    checks += 3;
    if (doned !== 1'b0) begin errors++; $display("FAIL reset_doned: %b, expected 0", doned); end
    if (busyd !== 1'b0) begin errors++; $display("FAIL reset_busyd: %b, expected 0", busyd); end
    if (countd !== 16'd0) begin errors++; $display("FAIL reset_countd: %0h, expected 0", countd); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_run();
    run4(32'd1, 0);
  endtask

  task automatic test_zero_start();
    run4(32'd0, 0);
  endtask

  task automatic test_overflow_wrap();
    run4(32'hFFFF_FFFF, 0);
  endtask

  task automatic test_go_mid_run();
    int e;
    e = push_run(32'd5);
    start4 = 32'd5;
    go4 = 1'b1;
    tick();
    go4 = 1'b0;
    wait_done4(e, 6);
    check_quiet(40);
    readback4();
  endtask

  task automatic test_go_held();
    int e;
    e = push_run(32'd2);
    start4 = 32'd2;
    go4 = 1'b1;
    tick();
    wait_done4(e, 0);
    tick();
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL held_go_restart: busy=%b, expected 1", busy4);
    end
    go4 = 1'b0;
    wait_done4(e, 0);
    check_quiet(2);
    readback4();
  endtask

  task automatic test_reset_mid_iter();
    start4 = 32'd1;
    go4 = 1'b1;
    tick();
    go4 = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    checks += 3;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL midreset_busy: %b, expected 0", busy4); end
    if (done4 !== 1'b0) begin errors++; $display("FAIL midreset_done: %b, expected 0", done4); end
    if (count4 !== 16'd0) begin errors++; $display("FAIL midreset_count: %0h, expected 0", count4); end
    reset = 1'b0;
    tick();
    run4(32'd1, 0);
  endtask

  task automatic test_default_27();
    int edges = 1;
    int t;
    int k = 0;
    bit seen = 0;
    logic [15:0] c;
    logic [15:0] last_c;
    for (int i = 0; i < 256; i++) begin
      model(32'd27 + 32'(i), c, t);
      edges += t + 2;
      last_c = c;
    end
    startd = 32'd27;
    god = 1'b1;
    tick();
    god = 1'b0;
    while (!seen && k < 60000) begin
      tick();
      k++;
      if (doned === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || k !== edges) begin
      errors++;
      $display("FAIL default_done_timing: done after %0d edges (seen=%0d), expected %0d", k, seen, edges);
    end
    startd = 32'd0;
    tick();
    checks++;
    if (countd !== 16'd112) begin
      errors++;
      $display("FAIL default_addr0: count=%0d, expected 112", countd);
    end
    startd = 32'd255;
    tick();
    checks++;
    if (countd !== last_c) begin
      errors++;
      $display("FAIL default_addr255: count=%0d, expected %0d", countd, last_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_start();
    test_overflow_wrap();
    test_go_mid_run();
    test_go_held();
    test_reset_mid_iter();
    test_default_27();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
